// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed path: sequencer state
// encoding and operand/accumulator widths also used by the pe cells.
package systolic_pkg;

  localparam int SYS_DW    = 16;
  localparam int SYS_ACC_W = 2*SYS_DW + 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FEED      = 3'd1,
    DRAIN     = 3'd2,
    FLUSH     = 3'd3,
    WAIT_CALC = 3'd4,
    DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/systolic_feed_ctrl_skew_delay.sv
// skew_delay: DEPTH-stage zero-reset shift register with enable.
// DEPTH=0 degenerates to a plain wire so lane 0 of the feed needs no special case.
module skew_delay import systolic_pkg::*; #(
  parameter int DW    = SYS_DW,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = clk ^ rst_n ^ en_i;
      assign q_o       = d_i;
    end else begin : g_sr
      logic [DEPTH-1:0][DW-1:0] sr_q;
      // shift one stage per enabled cycle; frozen when en_i is low
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sr_q <= '0;
        end else if (en_i) begin
          sr_q[0] <= d_i;
          for (int s = 1; s < DEPTH; s++) sr_q[s] <= sr_q[s-1];
        end
      end
      assign q_o = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: streams K operand words per lane from the activation and
// weight SRAMs into an N x N systolic array, skewing lane i by i cycles, then
// drains, pulses input_done and waits (with watchdog) for every pe's calc_done.
// Optional build macro SYSFEED_RUNTIME_LEN_EN adds a k_len_i port giving a
// per-run feed length (clamped to K, 0 skips the feed phase).
module systolic_feed_ctrl import systolic_pkg::*; #(
  parameter int N       = 4,
  parameter int K       = 4,
  parameter int DW      = SYS_DW,
  parameter int AW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            start_i,
`ifdef SYSFEED_RUNTIME_LEN_EN
  input  logic [AW:0]     k_len_i,
`endif
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            sram_rd_en_o,
  output logic [AW-1:0]   sram_addr_o,
  input  logic [N*DW-1:0] act_rd_data_i,
  input  logic [N*DW-1:0] wt_rd_data_i,
  output logic [N*DW-1:0] act_out_o,
  output logic [N*DW-1:0] wt_out_o,
  output logic            input_done_o,
  input  logic [N*N-1:0]  calc_done_i
);

  localparam int CW = $clog2(N+1);
  localparam int WW = $clog2(TIMEOUT+1);
  localparam logic [AW:0]   K_L     = (AW+1)'(K);
  localparam logic [CW-1:0] N_LAST  = CW'(N-1);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT-1);

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW:0]     len_q, len_d;
  logic [CW-1:0]   drn_q;
  logic [WW-1:0]   wdog_q;
  logic            rd_en_q, vld_q, busy_q, done_q, err_q, in_done_q;
  logic            addr_last;

`ifdef SYSFEED_RUNTIME_LEN_EN
  assign len_d = (k_len_i > K_L) ? K_L : k_len_i;
`else
  assign len_d = K_L;
`endif

  assign addr_last = ({1'b0, addr_q} == (len_q - 1'b1));

  // sequencer: one register set, all outputs registered, frozen when en_i is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      drn_q     <= '0;
      wdog_q    <= '0;
      rd_en_q   <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      in_done_q <= 1'b0;
    end else if (en_i) begin
      vld_q     <= rd_en_q;
      done_q    <= 1'b0;
      in_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            addr_q <= '0;
            drn_q  <= '0;
            len_q  <= len_d;
            if (len_d == '0) begin
              state_q <= DRAIN;
            end else begin
              state_q <= FEED;
              rd_en_q <= 1'b1;
            end
          end
        end
        FEED: begin
          if (addr_last) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drn_q == N_LAST) begin
            state_q   <= FLUSH;
            in_done_q <= 1'b1;
          end else begin
            drn_q <= drn_q + 1'b1;
          end
        end
        FLUSH: begin
          state_q <= WAIT_CALC;
          wdog_q  <= '0;
        end
        WAIT_CALC: begin
          if (&calc_done_i) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (wdog_q == TO_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The SRAM enable is qualified by en_i so a frozen cycle does not re-read:
  // the SRAM then keeps its last word, which lane 0 (a wire) relies on to hold.
  assign sram_rd_en_o = rd_en_q & en_i;
  assign sram_addr_o  = addr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign input_done_o = in_done_q;

  // Read data is only meaningful the cycle after a read; zero it otherwise so
  // the array edges see 0 outside each lane's window.
  logic [N-1:0][DW-1:0] act_in, wt_in, act_sk, wt_sk;
  assign act_in = vld_q ? act_rd_data_i : '0;
  assign wt_in  = vld_q ? wt_rd_data_i  : '0;

  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      skew_delay #(.DW(DW), .DEPTH(g)) u_act_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .d_i   (act_in[g]),
        .q_o   (act_sk[g])
      );
      skew_delay #(.DW(DW), .DEPTH(g)) u_wt_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .d_i   (wt_in[g]),
        .q_o   (wt_sk[g])
      );
    end
  endgenerate

  assign act_out_o = act_sk;
  assign wt_out_o  = wt_sk;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl (N=4, K=4, DW=16, TIMEOUT=64).
// Define SYSFEED_RUNTIME_LEN_EN on both RTL and bench to cover the k_len port.
module tb_systolic_feed_ctrl;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n, en, start;
  logic busy, done, err, sram_rd_en, input_done;
  logic [AW-1:0] sram_addr;
  logic [N-1:0][DW-1:0] act_rd = '1;
  logic [N-1:0][DW-1:0] wt_rd  = '1;
  logic [N*DW-1:0] act_out, wt_out;
  logic [N*N-1:0] calc_done;
`ifdef SYSFEED_RUNTIME_LEN_EN
  logic [AW:0] k_len = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_feed_ctrl #(.N(N), .K(K), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .start_i      (start),
`ifdef SYSFEED_RUNTIME_LEN_EN
    .k_len_i      (k_len),
`endif
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .sram_rd_en_o (sram_rd_en),
    .sram_addr_o  (sram_addr),
    .act_rd_data_i(act_rd),
    .wt_rd_data_i (wt_rd),
    .act_out_o    (act_out),
    .wt_out_o     (wt_out),
    .input_done_o (input_done),
    .calc_done_i  (calc_done)
  );

  // synchronous SRAM model: row k, lane i = 0x10*i + k (weights tagged with bit 15)
  always @(posedge clk) begin
    if (sram_rd_en) begin
      for (int i = 0; i < N; i++) begin
        act_rd[i] <= 16'(16*i) + 16'(sram_addr);
        wt_rd[i]  <= 16'h8000 | (16'(16*i) + 16'(sram_addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from start to one idle cycle after done. lc counts enabled
  // cycles since F, which is the design's logical time; expected values come
  // from the timing relations: lane i element k at lc=1+k+i, input_done at
  // lc=len+N, done at lc=len+N+2 (or after TIMEOUT WAIT cycles when stuck).
  task automatic run_txn(input int len, input int frz_at, input int frz_n,
                         input bit to, input bit repulse);
    int elen, lc, t, tdone, ndone, k;
    bit en_now;
    logic [N-1:0][DW-1:0] ea, ew;
    elen  = (len > K) ? K : len;
    tdone = elen + N + 1 + (to ? TO : 1);
    start = 1'b1;
    en    = 1'b1;
`ifdef SYSFEED_RUNTIME_LEN_EN
    k_len = (AW+1)'(len);
`endif
    tick();
    start = 1'b0;
    lc = 0; t = 0; ndone = 0;
    while (lc <= tdone + 1 && t < 300) begin
      en_now = !(t >= frz_at && t < frz_at + frz_n);
      en     = en_now;
      start  = repulse && (t == 2 || t == 7);
      #1;
      for (int i = 0; i < N; i++) begin
        k = lc - 1 - i;
        ea[i] = (k >= 0 && k < elen) ? 16'(16*i + k) : 16'h0;
        ew[i] = (k >= 0 && k < elen) ? (16'h8000 | 16'(16*i + k)) : 16'h0;
      end
      chk("act_out", act_out, ea);
      chk("wt_out", wt_out, ew);
      chk("busy", 64'(busy), 64'(lc <= tdone));
      chk("done", 64'(done), 64'(lc == tdone));
      chk("input_done", 64'(input_done), 64'(lc == elen + N));
      chk("rd_en", 64'(sram_rd_en), 64'(en_now && lc < elen));
      if (lc < elen) chk("addr", 64'(sram_addr), 64'(lc));
      chk("err", 64'(err), 64'(to && lc >= tdone));
      if (done) ndone++;
      tick();
      if (en_now) lc++;
      t++;
    end
    chk("done_count", 64'(ndone), 64'd1);
    chk("cycle_bound", 64'(t < 300), 64'd1);
    start = 1'b0;
    en    = 1'b1;
  endtask

  initial begin
    // reset with start held high: must be ignored
    rst_n = 1'b0; en = 1'b1; start = 1'b1; calc_done = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_en", 64'(sram_rd_en), 64'd0);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_act", act_out, 64'd0);
    chk("rst_wt", wt_out, 64'd0);
    chk("rst_in_done", 64'(input_done), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    tick();
    chk("post_rst_idle", 64'(busy), 64'd0);

    // nominal run: done at S+11
    calc_done = 16'hFFFF;
    run_txn(K, 1000, 0, 1'b0, 1'b0);
    // start re-pulsed at S+3 and S+8 is ignored
    run_txn(K, 1000, 0, 1'b0, 1'b1);
    // en low for 3 cycles from F+2
    run_txn(K, 2, 3, 1'b0, 1'b0);
    // stuck calc_done: watchdog, then the next start clears err
    calc_done = 16'hFFFE;
    run_txn(K, 1000, 0, 1'b1, 1'b0);
    calc_done = 16'hFFFF;
    run_txn(K, 1000, 0, 1'b0, 1'b0);

    // reset in DRAIN (F+K+1): IDLE next cycle, all zero, no done afterwards
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < K + 1; i++) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_act", act_out, 64'd0);
    chk("mid_rst_wt", wt_out, 64'd0);
    chk("mid_rst_rd_en", 64'(sram_rd_en), 64'd0);
    chk("mid_rst_addr", 64'(sram_addr), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("mid_rst_no_done", 64'(done | input_done | busy), 64'd0);
      tick();
    end
    run_txn(K, 1000, 0, 1'b0, 1'b0);

`ifdef SYSFEED_RUNTIME_LEN_EN
    run_txn(2, 1000, 0, 1'b0, 1'b0);
    run_txn(0, 1000, 0, 1'b0, 1'b0);
    run_txn(9, 1000, 0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
